// File: rtl/mm_accum_ctrl.sv
// mm_accum_ctrl: drives one shared saturating adder to compute C = A*B for one N x N signed product.
// Latency: triple c issued in cycle c, accumulated in c+1, C element written in c+2; done in cycle N^3+1.
// Backpressure: none; operands return at fixed latency and start is ignored while busy.
//
// Optional feature macro: MM_SAT_CNT_EN adds the 16-bit saturation event counter port sat_count.
//
// Ports:
//   clk, rst_n         : clock and synchronous active-low reset
//   start / busy / done: product request, in-progress flag, final-write pulse
//   a_addr, b_addr     : combinational A/B element addresses (i*N+k, k*N+j)
//   prod_in            : A[i][k]*B[k][j], valid one cycle after its addresses
//   sat_a, sat_b, sat_s: operands to and saturated sum from the external adder
//   c_we, c_addr, c_data: registered result-memory write
//   sat_count          : saturation event counter (MM_SAT_CNT_EN only)
module mm_accum_ctrl #(
  parameter int WIDTH = 14,
  parameter int N     = 4,
  parameter int AW    = $clog2(N*N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [AW-1:0]           a_addr,
  output logic [AW-1:0]           b_addr,
  input  logic signed [WIDTH-1:0] prod_in,
  output logic signed [WIDTH-1:0] sat_a,
  output logic signed [WIDTH-1:0] sat_b,
  input  logic signed [WIDTH-1:0] sat_s,
  output logic                    c_we,
  output logic [AW-1:0]           c_addr,
  output logic signed [WIDTH-1:0] c_data
`ifdef MM_SAT_CNT_EN
  ,
  output logic [15:0]             sat_count
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(N * N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // FSM and loop counters
  state_t          state_q, state_d;
  logic [CW-1:0]   i_q, i_d;
  logic [CW-1:0]   j_q, j_d;
  logic [CW-1:0]   k_q, k_d;
  logic            drain_q, drain_d;

  // Pipeline stage aligned with prod_in
  logic            vld_q, vld_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic [AW-1:0]   idx_q, idx_d;

  // Accumulator and registered outputs
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic                    c_we_q, c_we_d;
  logic [AW-1:0]           c_addr_q, c_addr_d;
  logic signed [WIDTH-1:0] c_data_q, c_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Adder operands. The first term of every element starts from zero rather
  // than from the previous element's sum, so acc never needs an explicit clear.
  always_comb begin
    sat_a = prod_in;
    sat_b = first_q ? '0 : acc_q;
  end

  // Element addresses follow the counters directly.
  always_comb begin
    a_addr = AW'(int'(i_q) * N + int'(k_q));
    b_addr = AW'(int'(k_q) * N + int'(j_q));
  end

  // Sequencer: k innermost, then j, then i; two drain cycles flush the
  // product and write stages before returning to idle.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    drain_d = drain_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    idx_d   = idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          busy_d  = 1'b1;
        end
      end

      S_ISSUE: begin
        vld_d   = 1'b1;
        first_d = (k_q == '0);
        last_d  = (k_q == CNT_LAST);
        idx_d   = AW'(int'(i_q) * N + int'(j_q));
        if (k_q == CNT_LAST) begin
          k_d = '0;
          if (j_q == CNT_LAST) begin
            j_d = '0;
            if (i_q == CNT_LAST) begin
              i_d     = '0;
              state_d = S_DRAIN;
              drain_d = 1'b0;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_DRAIN: begin
        if (drain_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Accumulate and write. The write data is the same saturated sum that is
  // loaded into acc, so c_data equals acc in the write cycle.
  always_comb begin
    acc_d    = acc_q;
    c_we_d   = 1'b0;
    done_d   = 1'b0;
    c_addr_d = c_addr_q;
    c_data_d = c_data_q;
    if (vld_q) begin
      acc_d = sat_s;
      if (last_q) begin
        c_we_d   = 1'b1;
        c_addr_d = idx_q;
        c_data_d = sat_s;
        done_d   = (idx_q == IDX_LAST);
      end
    end
  end

`ifdef MM_SAT_CNT_EN
  localparam logic signed [WIDTH:0] SUM_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] SUM_MIN = {2'b11, {(WIDTH-1){1'b0}}};

  logic [15:0]             sat_count_q, sat_count_d;
  logic signed [WIDTH:0]   sum_ext;
  logic                    sum_ovf;

  // Exact WIDTH+1-bit sum tells whether the adder had to clamp.
  always_comb begin
    sum_ext     = {sat_a[WIDTH-1], sat_a} + {sat_b[WIDTH-1], sat_b};
    sum_ovf     = (sum_ext > SUM_MAX) || (sum_ext < SUM_MIN);
    sat_count_d = sat_count_q;
    if (vld_q && sum_ovf && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      drain_q  <= 1'b0;
      vld_q    <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      c_we_q   <= 1'b0;
      c_addr_q <= '0;
      c_data_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      drain_q  <= drain_d;
      vld_q    <= vld_d;
      first_q  <= first_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      c_we_q   <= c_we_d;
      c_addr_q <= c_addr_d;
      c_data_q <= c_data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign c_we   = c_we_q;
  assign c_addr = c_addr_q;
  assign c_data = c_data_q;

endmodule

// File: tb/tb_mm_accum_ctrl.sv
// tb_mm_accum_ctrl: randomized product runs against a matrix-level reference model.
// Latency: expected write/done/busy cycles derived from N^3 issue order.
// Backpressure: n/a; bench models the fixed-latency operand path and the saturating adder.
module tb_mm_accum_ctrl;

  localparam int W    = 14;
  localparam int N    = 4;
  localparam int AW   = $clog2(N*N);
  localparam int NN   = N * N;
  localparam int N3   = N * N * N;
  localparam int VMAX = (1 <<< (W-1)) - 1;
  localparam int VMIN = -(1 <<< (W-1));

  logic                core_clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                busy, done;
  logic [AW-1:0]       a_addr, b_addr;
  logic signed [W-1:0] prod_in;
  logic signed [W-1:0] sat_a, sat_b, sat_s;
  logic                c_we;
  logic [AW-1:0]       c_addr;
  logic signed [W-1:0] c_data;
`ifdef MM_SAT_CNT_EN
  logic [15:0]         sat_count;
`endif

  always #5 core_clk = ~core_clk;

  mm_accum_ctrl #(.WIDTH(W), .N(N)) u_dut (
    .clk     (core_clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .a_addr  (a_addr),
    .b_addr  (b_addr),
    .prod_in (prod_in),
    .sat_a   (sat_a),
    .sat_b   (sat_b),
    .sat_s   (sat_s),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_data  (c_data)
`ifdef MM_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Matrices and product source: 0 = A*B from tables, 1 = all +5000, 2 = all -5000
  int mat_a [NN];
  int mat_b [NN];
  int mode = 0;
  int exp_sat_cnt = 0;

  task automatic chk_val(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int clampw(input int v);
    if (v > VMAX) return VMAX;
    if (v < VMIN) return VMIN;
    return v;
  endfunction

  function automatic int prod_of(input int aa, input int bb);
    if (mode == 1) return 5000;
    if (mode == 2) return -5000;
    return mat_a[aa] * mat_b[bb];
  endfunction

  // External saturating adder
  assign sat_s = W'(clampw(int'(sat_a) + int'(sat_b)));

  // External operand memories + multiplier: one-cycle latency from addresses
  int pa = 0;
  int pb = 0;
  always begin
    @(negedge core_clk);
    pa = int'(a_addr);
    pb = int'(b_addr);
    @(posedge core_clk);
    #1 prod_in = W'(prod_of(pa, pb));
  end

  task automatic fill_rand(input int lim);
    for (int e = 0; e < NN; e++) begin
      mat_a[e] = $urandom_range(2*lim) - lim;
      mat_b[e] = $urandom_range(2*lim) - lim;
    end
  endtask

  task automatic chk_idle_zero(input string pfx);
    chk_val({pfx, "_busy"},   int'(busy), 0);
    chk_val({pfx, "_done"},   int'(done), 0);
    chk_val({pfx, "_c_we"},   int'(c_we), 0);
    chk_val({pfx, "_c_addr"}, int'(c_addr), 0);
    chk_val({pfx, "_c_data"}, int'(c_data), 0);
    chk_val({pfx, "_a_addr"}, int'(a_addr), 0);
    chk_val({pfx, "_b_addr"}, int'(b_addr), 0);
    chk_val({pfx, "_sat_b"},  int'(sat_b), 0);
`ifdef MM_SAT_CNT_EN
    chk_val({pfx, "_sat_count"}, int'(sat_count), 0);
`endif
  endtask

  // One product run. start_again: cycle in which start is re-pulsed (-1 none);
  // rst_at: cycle in which reset is asserted (-1 none).
  task automatic run_product(input int start_again, input int rst_at);
    int exp_val [NN];
    int run_sat;
    int acc, s, e_idx, wr_cnt;
    bool_t_dummy: begin end
    run_sat = 0;
    for (int e = 0; e < NN; e++) begin
      acc = 0;
      for (int k = 0; k < N; k++) begin
        s = ((k == 0) ? 0 : acc) + prod_of((e / N) * N + k, k * N + (e % N));
        if (s > VMAX || s < VMIN) run_sat++;
        acc = clampw(s);
      end
      exp_val[e] = acc;
    end
    wr_cnt = 0;

    @(negedge core_clk);
    start = 1'b1;
    @(posedge core_clk);
    #1 start = 1'b0;

    for (int t = 0; t <= N3 + 2; t++) begin
      if (t == rst_at) begin
        rst_n = 1'b0;
        @(posedge core_clk);
        #1;
        chk_idle_zero("rst_mid");
        rst_n = 1'b1;
        exp_sat_cnt = 0;
        for (int u = 0; u < 2 * N + 2; u++) begin
          @(posedge core_clk);
          #1;
          chk_val("rst_no_we", int'(c_we), 0);
          chk_val("rst_no_busy", int'(busy), 0);
        end
        return;
      end
      start = (t == start_again) ? 1'b1 : 1'b0;
      chk_val("busy", int'(busy), (t <= N3 + 1) ? 1 : 0);
      chk_val("done", int'(done), (t == N3 + 1) ? 1 : 0);
      chk_val("c_we", int'(c_we),
              (t >= N + 1 && t <= N3 + 1 && ((t - N - 1) % N) == 0) ? 1 : 0);
      if (c_we) begin
        e_idx = (t - N - 1) / N;
        if (e_idx >= NN) e_idx = NN - 1;
        chk_val("c_addr", int'(c_addr), e_idx);
        chk_val("c_data", int'(c_data), exp_val[e_idx]);
        wr_cnt++;
      end
      @(posedge core_clk);
      #1;
    end
    start = 1'b0;
    chk_val("write_count", wr_cnt, NN);
    exp_sat_cnt = exp_sat_cnt + run_sat;
    if (exp_sat_cnt > 65535) exp_sat_cnt = 65535;
`ifdef MM_SAT_CNT_EN
    chk_val("sat_count", int'(sat_count), exp_sat_cnt);
`endif
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    prod_in = '0;
    repeat (3) @(posedge core_clk);
    #1;
    chk_idle_zero("reset");
    rst_n = 1'b1;

    // Identity A, random B
    mode = 0;
    fill_rand(10);
    for (int e = 0; e < NN; e++) mat_a[e] = ((e / N) == (e % N)) ? 1 : 0;
    run_product(-1, -1);

    // Positive then negative saturation, counter cumulative
    mode = 1;
    run_product(-1, -1);
    mode = 2;
    run_product(-1, -1);

    // Start pulsed while busy is ignored
    mode = 0;
    fill_rand(10);
    run_product(3, -1);

    // Reset mid-run, then a full product
    fill_rand(10);
    run_product(-1, 4);
    fill_rand(10);
    run_product(-1, -1);

    // Large random operands mixing saturated and in-range elements
    fill_rand(90);
    run_product(-1, -1);
    fill_rand(90);
    run_product(-1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_accum_ctrl.md
# mm_accum_ctrl

Sequencer that computes one N×N signed matrix product C = A·B by driving a single shared `adder_sat` instance as a saturating accumulator. It issues A/B element addresses to external operand memories and multiplier, folds the returned products into a running sum through the adder, and writes each finished C element to the result memory. It sits between the operand/product path and the result buffer in the matrix-multiplier top level.

## Interface
- `WIDTH`, 14: signed width of products, accumulator, adder ports and C data.
- `N`, 4: matrix dimension (square). Must be 2 or more.
- `AW`, $clog2(N*N): width of all element addresses.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle request to begin a product; sampled only in IDLE.
- `busy` output 1: high while a product is in progress.
- `done` output 1: one-cycle pulse, coincident with the final `c_we`.
- `a_addr` output AW: row-major index i*N+k of the A element.
- `b_addr` output AW: row-major index k*N+j of the B element.
- `prod_in` input WIDTH signed: A[i][k]·B[k][j], valid exactly one cycle after its addresses.
- `sat_a` output WIDTH signed: adder operand A, driven equal to `prod_in`.
- `sat_b` output WIDTH signed: adder operand B, 0 for the first term (k=0), otherwise the accumulator.
- `sat_s` input WIDTH signed: saturated sum returned by the adder.
- `c_we` output 1: write strobe for the result memory.
- `c_addr` output AW: row-major index i*N+j.
- `c_data` output WIDTH signed: finished C element.
- `sat_count` output 16: saturation event counter (only with `MM_SAT_CNT_EN`).

## Operation
- FSM states are IDLE, ISSUE and DRAIN.
- **IDLE**: if `start`=1 at a clock edge, clear i, j and k to 0 and move to ISSUE. Otherwise remain in IDLE.
- **ISSUE**: one (i,j,k) triple is issued per cycle. k is the innermost loop, then j, then i.
  - `a_addr` and `b_addr` are combinational from the counters.
  - After the triple (N-1,N-1,N-1) is issued, move to DRAIN.
- **DRAIN**: two cycles that flush the product and write pipeline, then return to IDLE.
- **Pipeline registers**: a valid bit, a first-term flag (k==0), a last-term flag (k==N-1) and the C index each follow the issued triple by one cycle, matching the `prod_in` latency.
- **Accumulator**: in the cycle where the pipelined valid bit is 1, `acc` is loaded with `sat_s` at the clock edge.
- **Write path**: when the last-term flag is set, the next cycle drives `c_we`=1, `c_data`=`acc` and `c_addr`=the pipelined index. All three are registered.
- **Saturation**: the adder's clamping to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1] is the only overflow rule. The controller performs no additional clamping.
- `start` while `busy` is ignored, with no restart and no queuing.
- `rst_n`=0 at any time returns the block to IDLE and clears every register and output on that edge. Any partial product is discarded, and no further `c_we` is issued.

## Timing
- Let edge E0 be the edge at which `start` is accepted. Cycle t is the t-th cycle after E0.
- Triple number c (0 ≤ c < N³) is issued in cycle c.
- Its product is added in cycle c+1.
- The write for an element ending at triple c occurs in cycle c+2.
- `busy` is high for cycles 0 through N³+1 inclusive, and low from cycle N³+2 onward.
- `done` is high only in cycle N³+1, together with the final `c_we`.
- `c_we` pulses for one cycle at a time, every N cycles, N² times in total.
- Reset values: `busy`=0, `done`=0, `c_we`=0, `c_addr`=0, `c_data`=0, `a_addr`=0, `b_addr`=0, `sat_b`=0, `acc`=0, `sat_count`=0.
- A new `start` is accepted in cycle N³+2 at the earliest. Back-to-back products therefore have one idle cycle between them.

## Configuration
- `MM_SAT_CNT_EN` defined: `sat_count` is present.
  - It increments once per accumulation whose exact WIDTH+1-bit sum (`sat_a`+`sat_b`) lies outside the WIDTH-bit signed range.
  - It saturates at 16'hFFFF, is cleared by reset, and is not cleared by `start`.
- `MM_SAT_CNT_EN` undefined: the `sat_count` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Identity product**: N=2, WIDTH=14, A=I, B=[[1,2],[3,4]] -> writes (addr,data) = (0,1),(1,2),(2,3),(3,4) in cycles 3,5,7,9; `done` in cycle 9; `busy` low in cycle 10.
- **Positive saturation**: N=2, all products 5000 -> every C element is 8191; with `MM_SAT_CNT_EN`, `sat_count`=4 after `done`.
- **Negative saturation**: N=2, all products -5000 -> every C element is -8192; `sat_count`=8 cumulative across both runs, with no reset between the two runs.
- **Start while busy**: pulse `start` again in cycle 3 -> it is ignored; exactly 4 writes occur and a single `done` in cycle 9.
- **Reset mid-operation**: `rst_n`=0 in cycle 4 -> from the next cycle all outputs are 0, state is IDLE and no `c_we` follows. A new `start` then produces a full, correct product.
- **Default size**: N=4, random products in ±100 -> 16 writes match a reference model; `done` in cycle 65.
